// File: rtl/prog_clock_divider_pkg.sv
// Shared definitions for the programmable clock divider and the display
// blocks that consume its LED output.
package prog_clock_divider_pkg;

  // LED drive modes
  localparam int unsigned LED_MODE_TOGGLE = 0;  // led flips on every tick
  localparam int unsigned LED_MODE_MSB    = 1;  // led mirrors the tick counter MSB

endpackage

// File: rtl/prog_clock_divider_prescaler.sv
// Prescaler for the programmable clock divider: counts system clocks within a
// period, owns the active and pending divide ratios, and flags the terminal
// edge of each period.
module prog_clock_divider_prescaler #(
  parameter int unsigned DIV_W       = 26,
  parameter int unsigned DIV_DEFAULT = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic             term,
  output logic             load_pending
);

  logic [DIV_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic [DIV_W-1:0] load_val;

  // A ratio of zero would never terminate; treat it as one.
  assign load_val = (div_value == '0) ? DIV_W'(1) : div_value;

  // div_cur is never zero, so div_cur-1 is the last count of the period.
  assign term = en && !clr && (pre_cnt_q == div_cur_q - DIV_W'(1));

  assign load_pending = pend_q;

  // Next-state for period counter and ratio registers.
  always_comb begin
    pre_cnt_d  = pre_cnt_q;
    div_cur_d  = div_cur_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    if (!en) begin
      // Stopped: a new ratio takes effect at once and restarts the period.
      if (div_load) begin
        div_cur_d = load_val;
        pre_cnt_d = '0;
        pend_d    = 1'b0;
      end
      if (clr) begin
        pre_cnt_d = '0;
      end
    end else begin
      if (clr) begin
        pre_cnt_d = '0;
      end else if (term) begin
        pre_cnt_d = '0;
        if (pend_q) begin
          div_cur_d = div_pend_q;
          pend_d    = 1'b0;
        end
      end else begin
        pre_cnt_d = pre_cnt_q + 1'b1;
      end
      // Running: park the ratio until the current period finishes.
      if (div_load) begin
        div_pend_d = load_val;
        pend_d     = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q  <= '0;
      div_cur_q  <= DIV_W'(DIV_DEFAULT);
      div_pend_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      div_cur_q  <= div_cur_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
    end
  end

endmodule

// File: rtl/prog_clock_divider.sv
// Run-time programmable clock divider: one-cycle tick every N clocks, a
// wrapping tick counter and an LED drive.
module prog_clock_divider
  import prog_clock_divider_pkg::*;
#(
  parameter int unsigned DIV_W       = 26,
  parameter int unsigned DIV_DEFAULT = 50000000,
  parameter int unsigned CNT_W       = 3,
  parameter int unsigned LED_MODE    = LED_MODE_TOGGLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic [CNT_W-1:0] count,
  output logic             led,
  output logic             tick,
  output logic             load_pending
);

  logic             term;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             led_q, led_d;

  prog_clock_divider_prescaler #(
    .DIV_W       (DIV_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_prescaler (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .clr          (clr),
    .div_load     (div_load),
    .div_value    (div_value),
    .term         (term),
    .load_pending (load_pending)
  );

  // Next-state for tick, tick counter and toggling LED.
  always_comb begin
    tick_d  = term;
    count_d = count_q;
    led_d   = led_q;
    if (clr) begin
      tick_d  = 1'b0;
      count_d = '0;
      led_d   = 1'b0;
    end else if (term) begin
      count_d = count_q + 1'b1;
      led_d   = ~led_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q  <= 1'b0;
      count_q <= '0;
      led_q   <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      count_q <= count_d;
      led_q   <= led_d;
    end
  end

  // LED source select.
  always_comb begin
    led = led_q;
    if (LED_MODE == LED_MODE_MSB) begin
      led = count_q[CNT_W-1];
    end
  end

  assign tick  = tick_q;
  assign count = count_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench for prog_clock_divider: directed scenarios plus random
// traffic, checked every clock against a tick-accounting reference model.
module tb_prog_clock_divider;

  localparam int unsigned DIV_W       = 8;
  localparam int unsigned CNT_W       = 3;
  localparam int unsigned DIV_DEFAULT = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic             clr;
  logic             div_load;
  logic [DIV_W-1:0] div_value;
  logic [CNT_W-1:0] count, count1;
  logic             led, led1;
  logic             tick, tick1;
  logic             load_pending, load_pending1;

  int errors = 0;
  int checks = 0;

  // Reference model: ratio, edges elapsed in the current period, total ticks
  // since reset/clr, and the parked ratio (if any).
  int m_ratio;
  int m_phase;
  int m_ticks;
  int m_pval;
  bit m_pend;
  bit m_tick;

  prog_clock_divider #(
    .DIV_W       (DIV_W),
    .DIV_DEFAULT (DIV_DEFAULT),
    .CNT_W       (CNT_W),
    .LED_MODE    (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .clr          (clr),
    .div_load     (div_load),
    .div_value    (div_value),
    .count        (count),
    .led          (led),
    .tick         (tick),
    .load_pending (load_pending)
  );

  prog_clock_divider #(
    .DIV_W       (DIV_W),
    .DIV_DEFAULT (DIV_DEFAULT),
    .CNT_W       (CNT_W),
    .LED_MODE    (1)
  ) dut_msb (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .clr          (clr),
    .div_load     (div_load),
    .div_value    (div_value),
    .count        (count1),
    .led          (led1),
    .tick         (tick1),
    .load_pending (load_pending1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_ratio = DIV_DEFAULT;
    m_phase = 0;
    m_ticks = 0;
    m_pval  = 0;
    m_pend  = 1'b0;
    m_tick  = 1'b0;
  endfunction

  // Advance the model by one rising edge using the inputs present at it.
  function automatic void model_edge();
    int v;
    v = (div_value == 0) ? 1 : int'(div_value);
    m_tick = 1'b0;
    if (!en) begin
      if (div_load) begin
        m_ratio = v;
        m_phase = 0;
        m_pend  = 1'b0;
      end
      if (clr) begin
        m_phase = 0;
        m_ticks = 0;
      end
    end else begin
      if (clr) begin
        m_phase = 0;
        m_ticks = 0;
      end else begin
        m_phase++;
        if (m_phase == m_ratio) begin
          m_phase = 0;
          m_tick  = 1'b1;
          m_ticks++;
          if (m_pend) begin
            m_ratio = m_pval;
            m_pend  = 1'b0;
          end
        end
      end
      if (div_load) begin
        m_pval = v;
        m_pend = 1'b1;
      end
    end
  endfunction

  function automatic void compare_outputs();
    check("tick", tick, m_tick);
    check("count", count, m_ticks % (1 << CNT_W));
    check("led_toggle", led, m_ticks % 2);
    check("load_pending", load_pending, m_pend);
    check("led_msb", led1, (m_ticks >> (CNT_W - 1)) % 2);
    check("tick_msb_inst", tick1, m_tick);
  endfunction

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1 compare_outputs();
  endtask

  // Asynchronous reset pulse between edges, spanning one rising edge.
  task automatic async_reset();
    #3 rst = 1'b1;
    #1;
    model_reset();
    compare_outputs();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    clr       = 1'b0;
    div_load  = 1'b0;
    div_value = '0;
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    check("reset_count", count, 0);
    check("reset_tick", tick, 0);

    // 1: reset mid-period discards a pending load; first tick 4 edges later
    en = 1'b1;
    repeat (2) step();
    div_load  = 1'b1;
    div_value = 8'd3;
    step();
    div_load = 1'b0;
    check("s1_pending_before_rst", load_pending, 1);
    #3 rst = 1'b1;
    #1;
    check("s1_rst_count", count, 0);
    check("s1_rst_tick", tick, 0);
    check("s1_rst_led", led, 0);
    check("s1_rst_pending", load_pending, 0);
    model_reset();
    step();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("s1_first_tick", tick, (i == 4) ? 1 : 0);
    end

    // 2: free run, count wraps at the 8th tick
    for (int k = 5; k <= 40; k++) begin
      step();
      if (k == 28) check("s2_count7", count, 7);
      if (k == 32) begin
        check("s2_wrap_count", count, 0);
        check("s2_wrap_tick", tick, 1);
      end
      if (k == 36) check("s2_led9", led, 1);
    end

    // 3: load ratio 2 at pre_cnt=1; old period completes first
    step();
    div_load  = 1'b1;
    div_value = 8'd2;
    step();
    div_load = 1'b0;
    check("s3_pending", load_pending, 1);
    step();
    check("s3_no_tick_yet", tick, 0);
    step();
    check("s3_old_boundary_tick", tick, 1);
    check("s3_pending_cleared", load_pending, 0);
    for (int j = 1; j <= 4; j++) begin
      step();
      check("s3_div2_tick", tick, (j % 2 == 0) ? 1 : 0);
    end

    // 4: ratio 0 loaded while stopped -> immediate ratio 1
    en        = 1'b0;
    div_load  = 1'b1;
    div_value = 8'd0;
    step();
    div_load = 1'b0;
    check("s4_no_pending", load_pending, 0);
    check("s4_count_held", count, 5);
    en = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      step();
      check("s4_tick_high", tick, 1);
      check("s4_count_inc", count, (5 + j) % 8);
    end

    // 5: freeze at pre_cnt=2, resume finishes the period in 2 clocks
    en        = 1'b0;
    div_load  = 1'b1;
    div_value = 8'd4;
    step();
    div_load = 1'b0;
    en       = 1'b1;
    repeat (2) step();
    en = 1'b0;
    for (int j = 0; j < 10; j++) begin
      step();
      check("s5_frozen_tick", tick, 0);
      check("s5_frozen_count", count, 0);
    end
    en = 1'b1;
    step();
    check("s5_resume_1", tick, 0);
    step();
    check("s5_resume_2", tick, 1);

    // 6: clr on a terminal edge with count=5
    repeat (19) step();
    check("s6_count5", count, 5);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("s6_clr_count", count, 0);
    check("s6_clr_tick", tick, 0);
    check("s6_clr_led", led, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("s6_next_tick", tick, (i == 4) ? 1 : 0);
    end
    check("s6_count1", count, 1);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      en        = ($urandom % 4) != 0;
      clr       = ($urandom % 25) == 0;
      div_load  = ($urandom % 10) == 0;
      div_value = DIV_W'($urandom % 6);
      if (($urandom % 150) == 0) begin
        async_reset();
      end else begin
        step();
      end
    end
    en       = 1'b0;
    clr      = 1'b0;
    div_load = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
